row_decoder_seq: RTL

Parametrised, registered successor to the fixed 3-to-8 row-select decoder used by the Hamming codeword storage array. It converts an ADDR_W-bit row address into a one-hot NUM_ROWS-bit row select through a valid/ready/ack handshake (direct mode). It can also sweep every row in order for scrub/syndrome-check passes (scan mode). It sits between the Hamming controller and the codeword memory rows.

---
 rtl/rowdec_pkg.sv | 20 ++
 rtl/row_decoder_seq_onehot_decode.sv | 22 ++
 rtl/row_decoder_seq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rowdec_pkg.sv
// rtl/rowdec_pkg.sv - shared state encodings, mode values and sizing helper for row_decoder_seq
package rowdec_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Bits needed to hold values 0..value-1; handy for non-power-of-two row counts.
  function automatic int rowdec_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/row_decoder_seq_onehot_decode.sv
// rtl/row_decoder_seq_onehot_decode.sv - combinational ADDR_W-to-NUM_ROWS one-hot decoder with in-range flag
module onehot_decode
  import rowdec_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int NUM_ROWS = 8
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_ROWS-1:0] sel,
  output logic                in_range
);

  // One extra bit so NUM_ROWS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] ROWS_EXT = (ADDR_W + 1)'(NUM_ROWS);

  assign in_range = {1'b0, addr} < ROWS_EXT;

  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_row
    assign sel[i] = in_range & (addr == ADDR_W'(i));
  end

endmodule

// File: rtl/row_decoder_seq.sv
// rtl/row_decoder_seq.sv - registered row-select decoder with direct and scan modes
// Optional ROWDEC_ONEHOT_CHECK_EN adds a sticky onehot_err output.
module row_decoder_seq
  import rowdec_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int NUM_ROWS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   address,
  input  logic                addr_valid,
  output logic                addr_ready,
  input  logic                scan_start,
  input  logic                row_ack,
  output logic [NUM_ROWS-1:0] row_select,
  output logic                row_valid,
  output logic [ADDR_W-1:0]   row_index,
  output logic                busy,
  output logic                scan_done,
  output logic                range_err
`ifdef ROWDEC_ONEHOT_CHECK_EN
  ,
  output logic                onehot_err
`endif
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ROWS - 1);

  logic [1:0]          state;
  logic [NUM_ROWS-1:0] dec_sel;
  logic                dec_in_range;
  logic                range_err_q;
  logic                scan_done_q;

  onehot_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_ROWS (NUM_ROWS)
  ) u_decode (
    .addr     (address),
    .sel      (dec_sel),
    .in_range (dec_in_range)
  );

  assign addr_ready = rst_n & en & (mode == MODE_DIRECT) & (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  // Pulses are masked while stalled and dropped on the stall edge so they never replay.
  assign range_err  = range_err_q & en;
  assign scan_done  = scan_done_q & en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      row_select  <= '0;
      row_index   <= '0;
      row_valid   <= 1'b0;
      range_err_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else if (!en) begin
      range_err_q <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      range_err_q <= 1'b0;
      scan_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mode == MODE_DIRECT) begin
            if (addr_valid) begin
              if (dec_in_range) begin
                row_select <= dec_sel;
                row_index  <= address;
                row_valid  <= 1'b1;
                state      <= ST_HOLD;
              end else begin
                range_err_q <= 1'b1;
              end
            end
          end else if (scan_start) begin
            row_select <= NUM_ROWS'(1);
            row_index  <= '0;
            row_valid  <= 1'b1;
            state      <= ST_SCAN;
          end
        end
        ST_HOLD: begin
          if (row_ack) begin
            row_select <= '0;
            row_index  <= '0;
            row_valid  <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (row_ack) begin
            // Last-row test comes first, so the index never overflows.
            if (row_index == LAST_IDX) begin
              row_select  <= '0;
              row_index   <= '0;
              row_valid   <= 1'b0;
              scan_done_q <= 1'b1;
              state       <= ST_DONE;
            end else begin
              row_select <= row_select << 1;
              row_index  <= row_index + ADDR_W'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ROWDEC_ONEHOT_CHECK_EN
  localparam int CNT_W = rowdec_clog2(NUM_ROWS + 1);

  logic [CNT_W-1:0] sel_count;

  always_comb begin
    sel_count = '0;
    for (int i = 0; i < NUM_ROWS; i++) sel_count = sel_count + CNT_W'(row_select[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      onehot_err <= 1'b0;
    end else if (row_valid ? (sel_count != CNT_W'(1)) : (sel_count != '0)) begin
      onehot_err <= 1'b1;
    end
  end
`endif

endmodule
